bta_pipe_n: RTL and testbench

Parametrised, pipelined multi-operand binary tree adder: sums N operands of W bits plus a carry-in through a ripple-carry adder tree with one register stage per tree level. It is the streaming successor of the fixed 8-operand tree adder. It adds a valid/ready handshake with backpressure, so it can sit between a producer and a consumer in the datapath. An optional running accumulator can be compiled in.

---
 rtl/bta_pipe_n_if.sv | 39 +++
 rtl/bta_pipe_n.sv | 129 ++++++++++++
 tb/tb_bta_pipe_n.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bta_pipe_n_if.sv
// bta_pipe_n_if: streaming handshake bundle for the pipelined tree adder.
// Carries the operand-side valid/ready pair, the packed operands with carry-in,
// and the result-side valid/ready pair with the exact-width sum.
// slave  : the adder itself (consumes operands, produces sums)
// master : the surrounding producer/consumer (or a testbench)
interface bta_pipe_n_if #(
    parameter int N = 8,
    parameter int W = 16
);
    localparam int L = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   ops;
    logic             c0;
    logic             out_valid;
    logic             out_ready;
    logic [W+L-1:0]   sum;

    modport slave (
        input  in_valid,
        input  ops,
        input  c0,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum
    );

    modport master (
        output in_valid,
        output ops,
        output c0,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum
    );
endinterface

// File: rtl/bta_pipe_n.sv
// bta_pipe_n: pipelined N-operand binary tree adder with valid/ready flow control.
// Level k of the tree adds pairs of (W+k)-bit partial sums into (W+k+1)-bit sums
// using ripple-carry adders, and each level is followed by one register stage
// with its own valid bit.  The whole pipe advances together unless the output
// is valid and the consumer is not ready, in which case every stage holds.
// The final stage is W+$clog2(N) bits wide, so the total never truncates.
//
// Optional feature macro: BTA_ACCUM_EN
//   When defined, adds acc_clr/acc ports and an ACC_W-bit running accumulator
//   that adds every sum leaving the block (acc_clr has priority and drops a
//   coincident sum).  When undefined the ports and logic are absent.
//
// N must be a power of two and at least 2; ACC_W must be at least W+$clog2(N).
// The interface instance must be built with the same N and W as this module.
module bta_pipe_n #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    bta_pipe_n_if.slave      bus
`ifdef BTA_ACCUM_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc
`endif
);

    localparam int L = $clog2(N);

    // Bit offset of level k's register bank inside the flat pipeline vector.
    // Level j holds N>>(j+1) sums of W+j+1 bits each, packed back to back.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += (N >> (j + 1)) * (W + j + 1);
        end
        return o;
    endfunction

    localparam int TOT   = lvl_off(L);
    localparam int LASTO = lvl_off(L - 1);

    logic [TOT-1:0] pipe_d;
    logic [TOT-1:0] pipe_q;
    logic [L-1:0]   v_q;
    logic           stall;

    // A stalled output freezes the entire pipe, so no stage ever overwrites
    // a result that is still waiting to be taken.
    assign stall         = v_q[L-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_q[L-1];
    assign bus.sum       = pipe_q[LASTO +: W+L];

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int IW    = W + k;
        localparam int OW    = W + k + 1;
        localparam int CNT   = N >> (k + 1);
        localparam int OFF   = lvl_off(k);
        localparam int INOFF = (k == 0) ? 0 : lvl_off(k - 1);

        for (genvar i = 0; i < CNT; i++) begin : g_pair
            logic [IW-1:0] opa;
            logic [IW-1:0] opb;
            logic          cin;
            logic          carry;
            logic [OW-1:0] s;

            if (k == 0) begin : g_first
                assign opa = bus.ops[(2*i)*W +: W];
                assign opb = bus.ops[(2*i+1)*W +: W];
            end else begin : g_inner
                assign opa = pipe_q[INOFF + (2*i)*IW +: IW];
                assign opb = pipe_q[INOFF + (2*i+1)*IW +: IW];
            end

            if (k == 0 && i == 0) begin : g_cin
                assign cin = bus.c0;
            end else begin : g_nocin
                assign cin = 1'b0;
            end

            // Ripple-carry adder: carry propagates LSB to MSB and becomes the new top bit.
            always_comb begin
                carry = cin;
                s     = '0;
                for (int b = 0; b < IW; b++) begin
                    s[b]  = opa[b] ^ opb[b] ^ carry;
                    carry = (opa[b] & opb[b]) | (carry & (opa[b] ^ opb[b]));
                end
                s[OW-1] = carry;
            end

            assign pipe_d[OFF + i*OW +: OW] = s;
        end
    end

    // Pipeline registers: every stage and valid bit moves one step unless stalled;
    // bubbles advance like data so the latency is fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
            v_q    <= '0;
        end else if (!stall) begin
            pipe_q <= pipe_d;
            v_q[0] <= bus.in_valid;
            for (int k = 1; k < L; k++) begin
                v_q[k] <= v_q[k-1];
            end
        end
    end

`ifdef BTA_ACCUM_EN
    // Running total of delivered sums; a clear wins over a same-cycle transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            acc <= acc + ACC_W'(bus.sum);
        end
    end
`endif

endmodule

// File: tb/tb_bta_pipe_n.sv
// tb_bta_pipe_n: scoreboard bench for bta_pipe_n with N=8, W=16 (L=3).
// Accepted operand sets push their model sum into a queue; the negedge monitor
// pops and compares whenever the DUT hands a result over.
// Accumulator scenarios are included when BTA_ACCUM_EN is defined.
module tb_bta_pipe_n;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int L  = 3;
    localparam int SW = W + L;
    localparam int ACC_W = 32;

    typedef struct {
        logic [SW-1:0] sum;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    logic clk;
    logic rst;
`ifdef BTA_ACCUM_EN
    logic             acc_clr;
    logic [ACC_W-1:0] acc;
`endif

    bta_pipe_n_if #(.N(N), .W(W)) bus ();

    bta_pipe_n #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave)
`ifdef BTA_ACCUM_EN
        ,
        .acc_clr (acc_clr),
        .acc     (acc)
`endif
    );

    exp_t          sb[$];
    int            tests_run;
    int            tests_failed;
    int            cyc;
    bit            lat_en;
    bit            held_valid;
    logic [SW-1:0] held_sum;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure latency from the accepting edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] modelSum(input logic [N*W-1:0] ops, input logic c0);
        int unsigned total;
        total = {31'd0, c0};
        for (int i = 0; i < N; i++) begin
            total += {16'd0, ops[i*W +: W]};
        end
        return total[SW-1:0];
    endfunction

    function automatic logic [N*W-1:0] constOps(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] rampOps(input int base);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + i);
        return r;
    endfunction

    function automatic logic [N*W-1:0] oneOps(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[W-1:0] = v;
        return r;
    endfunction

    // Drive one operand set (called #1 after a posedge) and hold it until accepted.
    task automatic applyStimulus(input logic [N*W-1:0] ops, input logic c0);
        exp_t e;
        bit   done;
        int   n;
        bus.in_valid = 1'b1;
        bus.ops      = ops;
        bus.c0       = c0;
        done = 1'b0;
        n    = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.sum     = modelSum(ops, c0);
                e.acc_cyc = cyc + 1;
                e.chk_lat = lat_en;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) checkOutput("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic idleCycles(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pops on transfers, hold-stability and in_ready checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            checkOutput("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (held_valid) begin
                checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("hold_sum", 64'(bus.sum), 64'(held_sum));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 64'(bus.sum), 64'hDEAD_0000);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sum", 64'(bus.sum), 64'(e.sum));
                    if (e.chk_lat) checkOutput("latency", 64'(cyc - e.acc_cyc), 64'(L - 1));
                end
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_sum   = bus.sum;
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        lat_en       = 1'b1;
        held_valid   = 1'b0;
        held_sum     = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.ops      = constOps(16'hA5A5);
        bus.c0       = 1'b1;
        bus.out_ready = 1'b1;
`ifdef BTA_ACCUM_EN
        acc_clr = 1'b0;
`endif

        // Reset held with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
            checkOutput("rst_sum", 64'(bus.sum), 64'd0);
            checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef BTA_ACCUM_EN
            checkOutput("rst_acc", 64'(acc), 64'd0);
`endif
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Extremes.
        applyStimulus(constOps(16'hFFFF), 1'b1);
        applyStimulus(constOps(16'h0000), 1'b0);
        waitDrain();

        // Streaming on consecutive cycles.
        applyStimulus(rampOps(1), 1'b0);
        applyStimulus(rampOps(2), 1'b1);
        applyStimulus(constOps(16'h1000), 1'b0);
        waitDrain();

        // Backpressure: out_ready pattern 1,0,0,1,0,1 repeating.
        lat_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                bit pat [6];
                pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
                for (int j = 0; j < 24; j++) begin
                    bus.out_ready = pat[j % 6];
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        lat_en = 1'b1;

        // Reset while two sets are in flight: neither may appear.
        applyStimulus(constOps(16'h1111), 1'b0);
        applyStimulus(constOps(16'h2222), 1'b1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        sb.delete();
        #1;
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(bus.sum), 64'd0);
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("midrst_idle", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(rampOps(100), 1'b1);
        waitDrain();

`ifdef BTA_ACCUM_EN
        // Accumulator: clear, then 0x10 + 0x20.
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        checkOutput("acc_clear", 64'(acc), 64'd0);
        applyStimulus(oneOps(16'h0010), 1'b0);
        applyStimulus(oneOps(16'h0020), 1'b0);
        waitDrain();
        checkOutput("acc_total", 64'(acc), 64'h30);

        // Clear coincident with a transfer of 0x5.
        bus.out_ready = 1'b0;
        applyStimulus(oneOps(16'h0005), 1'b0);
        bus.in_valid = 1'b0;
        for (int n = 0; n < 10 && !bus.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("acc_wait_valid", 64'(bus.out_valid), 64'd1);
        acc_clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        checkOutput("acc_clr_xfer", 64'(acc), 64'd0);
        waitDrain();
`else
        applyStimulus(oneOps(16'h0005), 1'b1);
        waitDrain();
`endif

        idleCycles(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        checkOutput("global_timeout", 64'd1, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
